// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction
// classes, opcode/funct constants, datapath mux/op codes and halt causes.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_WB_ALU = 4'd5,
        S_WB_MEM = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    // ori and lui share a class: both write rt with the ALU result
    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_OR   = 3'b010;
    localparam logic [2:0] ALUOP_SLT  = 3'b011;
    localparam logic [2:0] ALUOP_LUI  = 3'b100;

    localparam logic [1:0] EXTOP_ZERO  = 2'b00;
    localparam logic [1:0] EXTOP_SIGN  = 2'b01;
    localparam logic [1:0] EXTOP_UPPER = 2'b10;

    localparam logic [1:0] NPC_SEL_PC4    = 2'b00;
    localparam logic [1:0] NPC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] NPC_SEL_JIMM   = 2'b10;
    localparam logic [1:0] NPC_SEL_JREG   = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEM2REG_ALU = 2'b00;
    localparam logic [1:0] MEM2REG_RAM = 2'b01;
    localparam logic [1:0] MEM2REG_PC4 = 2'b10;

    localparam logic ALUSRC_GPR = 1'b0;
    localparam logic ALUSRC_EXT = 1'b1;

    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_ILLEGAL = 2'b01;
    localparam logic [1:0] HALT_IMEM    = 2'b10;
    localparam logic [1:0] HALT_DMEM    = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class plus the
// ALU/EXT control fields used from EXEC onward.
module mc_decode
    import mc_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       alu_src
);

    always_comb begin
        iclass  = CLS_ILLEGAL;
        alu_op  = ALUOP_ADD;
        ext_op  = EXTOP_ZERO;
        alu_src = ALUSRC_GPR;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADDU: iclass = CLS_ALU_R;
                    FUNCT_SUBU: begin
                        iclass = CLS_ALU_R;
                        alu_op = ALUOP_SUB;
                    end
                    FUNCT_SLT: begin
                        iclass = CLS_ALU_R;
                        alu_op = ALUOP_SLT;
                    end
                    FUNCT_JR: iclass = CLS_JR;
                    default:  iclass = CLS_ILLEGAL;
                endcase
            end
            OP_ORI: begin
                iclass  = CLS_ALU_I;
                alu_op  = ALUOP_OR;
                ext_op  = EXTOP_ZERO;
                alu_src = ALUSRC_EXT;
            end
            OP_LUI: begin
                iclass  = CLS_ALU_I;
                alu_op  = ALUOP_LUI;
                ext_op  = EXTOP_UPPER;
                alu_src = ALUSRC_EXT;
            end
            OP_LW, OP_SW: begin
                iclass  = (opcode == OP_LW) ? CLS_LW : CLS_SW;
                alu_op  = ALUOP_ADD;
                ext_op  = EXTOP_SIGN;
                alu_src = ALUSRC_EXT;
            end
            OP_BEQ:  iclass = CLS_BEQ;
            OP_J:    iclass = CLS_J;
            OP_JAL:  iclass = CLS_JAL;
            default: iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the MIPS datapath with memory wait states,
// retired-instruction counter and sticky halt on illegal opcode or timeout.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ICNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              alu_zero,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              IRWr,
    output logic              PCWr,
    output logic [1:0]        NPCSel,
    output logic [1:0]        RegDst,
    output logic              ALUSrc,
    output logic [1:0]        Mem2Reg,
    output logic              RegWr,
    output logic              MemWr,
    output logic [1:0]        EXTOp,
    output logic [2:0]        ALUOp,
    output logic [3:0]        state,
    output logic              halt,
    output logic [1:0]        halt_cause,
    output logic [ICNT_W-1:0] icount
);

    // The counter only has to hold 0..TIMEOUT-1; reaching TIMEOUT halts instead.
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_reg, state_next;
    logic [1:0]        halt_cause_reg, halt_cause_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [ICNT_W-1:0] icount_reg;
    logic              waiting;
    logic              wait_hit;
    logic              retire;

    iclass_t    iclass;
    logic [2:0] dec_alu_op;
    logic [1:0] dec_ext_op;
    logic       dec_alu_src;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .iclass  (iclass),
        .alu_op  (dec_alu_op),
        .ext_op  (dec_ext_op),
        .alu_src (dec_alu_src)
    );

    assign wait_hit = (TIMEOUT != 0) && (32'(wait_cnt_reg) == TIMEOUT - 1);

    always_comb begin
        state_next      = state_reg;
        halt_cause_next = halt_cause_reg;
        waiting         = 1'b0;
        IRWr            = 1'b0;
        PCWr            = 1'b0;
        RegWr           = 1'b0;
        MemWr           = 1'b0;
        NPCSel          = NPC_SEL_PC4;
        RegDst          = REGDST_RT;
        Mem2Reg         = MEM2REG_ALU;
        ALUSrc          = ALUSRC_GPR;
        EXTOp           = EXTOP_ZERO;
        ALUOp           = ALUOP_ADD;
        // EXEC controls stay on the ALU through the following memory/writeback step
        if (state_reg inside {S_EXEC, S_MEMRD, S_MEMWR, S_WB_ALU}) begin
            ALUSrc = dec_alu_src;
            EXTOp  = dec_ext_op;
            ALUOp  = dec_alu_op;
        end
        case (state_reg)
            S_FETCH: begin
                if (imem_ready) begin
                    IRWr       = 1'b1;
                    PCWr       = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (wait_hit) begin
                        state_next      = S_HALT;
                        halt_cause_next = HALT_IMEM;
                    end
                end
            end
            S_DECODE: begin
                case (iclass)
                    CLS_ALU_R, CLS_ALU_I, CLS_LW, CLS_SW: state_next = S_EXEC;
                    CLS_BEQ:                              state_next = S_BRANCH;
                    CLS_J, CLS_JAL, CLS_JR:               state_next = S_JUMP;
                    default: begin
                        state_next      = S_HALT;
                        halt_cause_next = HALT_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                if (iclass == CLS_LW)      state_next = S_MEMRD;
                else if (iclass == CLS_SW) state_next = S_MEMWR;
                else                       state_next = S_WB_ALU;
            end
            S_MEMRD, S_MEMWR: begin
                if (dmem_ready) begin
                    MemWr      = (state_reg == S_MEMWR);
                    state_next = (state_reg == S_MEMWR) ? S_FETCH : S_WB_MEM;
                end else begin
                    waiting = 1'b1;
                    if (wait_hit) begin
                        state_next      = S_HALT;
                        halt_cause_next = HALT_DMEM;
                    end
                end
            end
            S_WB_ALU: begin
                RegWr      = 1'b1;
                RegDst     = (iclass == CLS_ALU_R) ? REGDST_RD : REGDST_RT;
                state_next = S_FETCH;
            end
            S_WB_MEM: begin
                RegWr      = 1'b1;
                Mem2Reg    = MEM2REG_RAM;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUOp      = ALUOP_SUB;
                ALUSrc     = ALUSRC_GPR;
                NPCSel     = NPC_SEL_BRANCH;
                PCWr       = alu_zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                PCWr   = 1'b1;
                NPCSel = (iclass == CLS_JR) ? NPC_SEL_JREG : NPC_SEL_JIMM;
                if (iclass == CLS_JAL) begin
                    RegWr   = 1'b1;
                    RegDst  = REGDST_RA;
                    Mem2Reg = MEM2REG_PC4;
                end
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
        // Reset forces FETCH asynchronously; keep its strobes from leaking out meanwhile
        if (!rst) begin
            IRWr  = 1'b0;
            PCWr  = 1'b0;
            RegWr = 1'b0;
            MemWr = 1'b0;
        end
    end

    assign wait_cnt_next = (waiting && state_next == state_reg) ? wait_cnt_reg + WAIT_W'(1)
                                                                : '0;
    assign retire = (state_next == S_FETCH) && (state_reg != S_FETCH) && (state_reg != S_HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_FETCH;
            halt_cause_reg <= HALT_NONE;
            wait_cnt_reg   <= '0;
            icount_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            halt_cause_reg <= halt_cause_next;
            wait_cnt_reg   <= wait_cnt_next;
            if (retire) icount_reg <= icount_reg + ICNT_W'(1);
        end
    end

    assign state      = state_reg;
    assign halt       = (state_reg == S_HALT);
    assign halt_cause = halt_cause_reg;
    assign icount     = icount_reg;

endmodule
